// File: rtl/uart_rx_if.sv
// uart_rx_if: consumer-side handshake between the UART receiver
// and whatever drains its bytes.
interface uart_rx_if;
  logic [7:0] RXData;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output RXData,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ack
  );

  modport slave (
    input  RXData,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, LSB first, with break hold-off and
// sticky overrun on an unacknowledged byte.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd,
  uart_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    index;
  logic [7:0]    shift;
  logic [1:0]    sync;
  logic          rxd_s;
  logic          tick;
  logic          done;

  assign rxd_s    = sync[1];
  assign tick     = cnt == LAST;
  assign done     = state == STOP && tick && rxd_s;
  assign bus.busy = state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= 2'b11;
      state         <= IDLE;
      cnt           <= '0;
      index         <= '0;
      shift         <= '0;
      bus.RXData    <= 8'h00;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      sync          <= {sync[0], rxd};
      bus.frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              index <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shift <= {rxd_s, shift[7:1]};
            cnt   <= '0;
            index <= index + 1'b1;
            if (index == 3'd7)
              state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              state         <= BRK;
              bus.frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          if (rxd_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // a completing byte wins over a same-cycle acknowledge
      if (done) begin
        bus.RXData   <= shift;
        bus.rx_valid <= 1'b1;
        bus.overrun  <= (bus.overrun | bus.rx_valid) & ~bus.rx_ack;
      end else if (bus.rx_ack) begin
        bus.rx_valid <= 1'b0;
        bus.overrun  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a byte-level model of the
// receiver's consumer-visible outputs.
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic rxd;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cycles = 0;
  int fe0;
  int lat;
  int lat2;
  int use_lat;
  bit chk_en = 1'b0;

  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_ovr;
  logic       exp_busy;

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_lat(string name, int c);
    n_cmp++;
    if (c < 155 || c > 156) begin
      n_err++;
      $display("FAIL %s: got %0d cycles want 155..156", name, c);
    end
  endtask

  function automatic void m_reset();
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_busy  = 1'b0;
  endfunction

  // a good frame lands in the holding register
  function automatic void m_deliver(logic [7:0] b, bit ack_same);
    if (exp_valid && !ack_same)
      exp_ovr = 1'b1;
    if (ack_same)
      exp_ovr = 1'b0;
    exp_data  = b;
    exp_valid = 1'b1;
  endfunction

  function automatic void m_ack();
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_data", bus.RXData, exp_data);
      chk("rx_valid", 8'(bus.rx_valid), 8'(exp_valid));
      chk("overrun", 8'(bus.overrun), 8'(exp_ovr));
      chk("frame_err", 8'(bus.frame_err), 8'h00);
      chk("busy", 8'(bus.busy), 8'(exp_busy));
    end
  end

  always @(negedge clk)
    if (bus.frame_err === 1'b1)
      fe_cycles++;

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // leaves rxd at the stop level
  task automatic send_frame(logic [7:0] b, bit stop);
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(CPB);
    end
    rxd = stop;
    wait_cyc(CPB);
  endtask

  task automatic measure_frame(logic [7:0] b, output int cycles);
    int c;
    c = -1;
    fork
      send_frame(b, 1'b1);
      begin
        for (int k = 1; k <= 200; k++) begin
          @(negedge clk);
          if (bus.rx_valid === 1'b1) begin
            c = k;
            break;
          end
        end
      end
    join
    cycles = c;
  endtask

  task automatic do_ack();
    chk_en = 1'b0;
    bus.rx_ack = 1'b1;
    wait_cyc(1);
    bus.rx_ack = 1'b0;
    m_ack();
    chk_en = 1'b1;
    wait_cyc(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] part;
    rst = 1'b1;
    rxd = 1'b1;
    bus.rx_ack = 1'b0;
    m_reset();
    wait_cyc(2);
    chk_en = 1'b1;
    rxd = 1'b0;
    bus.rx_ack = 1'b1;
    wait_cyc(4);
    rxd = 1'b1;
    bus.rx_ack = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);
    chk("rst_data", bus.RXData, 8'h00);

    // clean frame
    chk_en = 1'b0;
    measure_frame(8'hA5, lat);
    chk_lat("latency_a5", lat);
    wait_cyc(2);
    m_deliver(8'hA5, 1'b0);
    chk_en = 1'b1;
    wait_cyc(3);
    chk("a5_data", bus.RXData, 8'hA5);
    chk("a5_valid", 8'(bus.rx_valid), 8'h01);
    chk("a5_busy", 8'(bus.busy), 8'h00);
    do_ack();
    chk("a5_ack_valid", 8'(bus.rx_valid), 8'h00);
    do_ack();
    chk("idle_ack_data", bus.RXData, 8'hA5);

    // false start
    fe0 = fe_cycles;
    chk_en = 1'b0;
    rxd = 1'b0;
    wait_cyc(4);
    chk("glitch_busy", 8'(bus.busy), 8'h01);
    rxd = 1'b1;
    wait_cyc(20);
    chk_en = 1'b1;
    wait_cyc(2);
    chk("glitch_idle", 8'(bus.busy), 8'h00);
    chk("glitch_fe", 8'(fe_cycles - fe0), 8'h00);

    // bad stop bit followed by a held-low line
    fe0 = fe_cycles;
    chk_en = 1'b0;
    send_frame(8'h3C, 1'b0);
    wait_cyc(40);
    chk("brk_busy", 8'(bus.busy), 8'h01);
    chk("brk_valid", 8'(bus.rx_valid), 8'h00);
    chk("brk_data", bus.RXData, 8'hA5);
    chk("brk_fe_pulse", 8'(fe_cycles - fe0), 8'h01);
    rxd = 1'b1;
    wait_cyc(5);
    chk_en = 1'b1;
    wait_cyc(3);
    chk("brk_release", 8'(bus.busy), 8'h00);

    // back-to-back without ack
    chk_en = 1'b0;
    send_frame(8'h01, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(2);
    m_deliver(8'h01, 1'b0);
    m_deliver(8'hFF, 1'b0);
    chk_en = 1'b1;
    wait_cyc(3);
    chk("ovr_data", bus.RXData, 8'hFF);
    chk("ovr_valid", 8'(bus.rx_valid), 8'h01);
    chk("ovr_flag", 8'(bus.overrun), 8'h01);
    do_ack();
    chk("ovr_ack_valid", 8'(bus.rx_valid), 8'h00);
    chk("ovr_ack_flag", 8'(bus.overrun), 8'h00);

    // reset in the middle of a frame
    chk_en = 1'b0;
    part = 8'h77;
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = part[i];
      wait_cyc(CPB);
    end
    rst = 1'b1;
    rxd = 1'b1;
    bus.rx_ack = 1'b1;
    wait_cyc(2);
    m_reset();
    chk_en = 1'b1;
    wait_cyc(1);
    chk("mid_rst_data", bus.RXData, 8'h00);
    chk("mid_rst_busy", 8'(bus.busy), 8'h00);
    bus.rx_ack = 1'b0;
    rst = 1'b0;
    wait_cyc(5);
    chk_en = 1'b0;
    measure_frame(8'h5A, lat2);
    chk_lat("latency_5a", lat2);
    wait_cyc(2);
    m_deliver(8'h5A, 1'b0);
    chk_en = 1'b1;
    wait_cyc(3);
    chk("5a_data", bus.RXData, 8'h5A);
    chk("5a_valid", 8'(bus.rx_valid), 8'h01);

    // ack lands in the completion cycle
    use_lat = (lat > 1) ? lat : 155;
    chk_en = 1'b0;
    fork
      send_frame(8'h12, 1'b1);
      begin
        wait_cyc(use_lat - 1);
        bus.rx_ack = 1'b1;
        wait_cyc(1);
        bus.rx_ack = 1'b0;
      end
    join
    wait_cyc(2);
    m_deliver(8'h12, 1'b1);
    chk_en = 1'b1;
    wait_cyc(3);
    chk("same_ack_data", bus.RXData, 8'h12);
    chk("same_ack_valid", 8'(bus.rx_valid), 8'h01);
    chk("same_ack_ovr", 8'(bus.overrun), 8'h00);
    do_ack();
    chk("final_valid", 8'(bus.rx_valid), 8'h00);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are even and >= 4.
REQ-002 Port: clk  input  1  system clock; all logic is rising-edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: rxd  input  1  asynchronous serial line; idles high; frame is 8N1, LSB first.
REQ-005 Port: rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun.
REQ-006 Port: RXData  output  8  last correctly framed received byte.
REQ-007 Port: rx_valid  output  1  RXData holds an unacknowledged byte.
REQ-008 Port: frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 Port: overrun  output  1  sticky flag: a byte completed while rx_valid was already 1.
REQ-010 Port: busy  output  1  high in every state except IDLE.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer (rxd_s) before any use; both flops reset to 1.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP and BRK.
REQ-013 Bit counter cnt SHALL be wide enough for CLKS_PER_BIT-1; bit index SHALL be 3 bits.
REQ-014 IDLE: rxd_s==0 SHALL cause a move to START with cnt=0.
REQ-015 START: at cnt==CLKS_PER_BIT/2-1, rxd_s==0 SHALL cause a move to DATA (cnt=0, index=0); rxd_s==1 SHALL be treated as a false start and return to IDLE.
REQ-016 DATA: at each cnt==CLKS_PER_BIT-1, the block SHALL shift right with rxd_s into bit 7, reset cnt to 0 and increment the index; after the 8th sample it SHALL move to STOP.
REQ-017 STOP with rxd_s==1 at cnt==CLKS_PER_BIT-1: RXData <= shift register, rx_valid <= 1, move to IDLE.
REQ-018 STOP with rxd_s==0 at cnt==CLKS_PER_BIT-1: frame_err pulses for 1 cycle, RXData and rx_valid are unchanged, move to BRK.
REQ-019 BRK SHALL remain in BRK until rxd_s==1, then move to IDLE, so a held-low line never starts a frame.
REQ-020 Overrun: when REQ-017 fires with rx_valid==1 and rx_ack==0, RXData SHALL be overwritten and overrun set to 1.
REQ-021 rx_ack==1 SHALL clear rx_valid and overrun the next cycle, unless REQ-017 fires in the same cycle.
REQ-022 If REQ-017 fires in the same cycle as rx_ack, rx_valid SHALL stay 1 and overrun SHALL NOT be set.
REQ-023 rx_ack while rx_valid==0 SHALL have no effect.
REQ-024 rx_valid SHALL assert between 9.5*CLKS_PER_BIT+2 and 9.5*CLKS_PER_BIT+4 cycles after the start-bit falling edge on rxd.
REQ-025 busy SHALL be combinational from the state: 0 in IDLE, 1 otherwise.

Reset
REQ-026 While rst==1: state=IDLE, cnt=0, index=0, shift=0, RXData=8'h00, rx_valid=0, frame_err=0, overrun=0, synchronizer=1.
REQ-027 rst SHALL override every event in the same cycle, including rx_ack and a frame in progress.
REQ-028 A reset mid-frame SHALL discard the partial byte; reception SHALL resume only on the next falling edge after rst deasserts.

Verification
REQ-029 CLKS_PER_BIT=16, frame 0xA5 (stop=1) -> RXData=8'hA5, rx_valid=1, frame_err=0, overrun=0, busy=0 after completion.
REQ-030 rxd low for 4 cycles, then high -> START aborts, rx_valid=0, frame_err=0, state returns to IDLE.
REQ-031 Frame 0x3C with stop=0, then rxd held low for 40 cycles -> frame_err single pulse, RXData unchanged, rx_valid=0, no new frame until rxd returns high.
REQ-032 Frames 0x01 then 0xFF back-to-back with no ack -> RXData=8'hFF, rx_valid=1, overrun=1; rx_ack for 1 cycle -> rx_valid=0, overrun=0.
REQ-033 rst pulsed after 4 data bits of 0x77, then a full frame 0x5A -> all outputs at reset values, then RXData=8'h5A and rx_valid=1.
REQ-034 rx_ack asserted in the exact cycle 0x12 completes while rx_valid==1 -> RXData=8'h12, rx_valid=1, overrun=0.
